// File: rtl/mdu_sched_pkg.sv
// Shared definitions for the multiply/divide scheduler: op encodings,
// default latencies and small decode helpers.
package mdu_sched_pkg;

   localparam int unsigned MD_WIDTH   = 32;
   localparam int unsigned MUL_CYCLES = 5;
   localparam int unsigned DIV_CYCLES = 10;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5,
      MD_RSV6  = 3'd6,
      MD_RSV7  = 3'd7
   } md_op_e;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_RUN  = 1'b1
   } md_state_e;

   // Ops that occupy the unit for several cycles.
   function automatic logic md_is_multi(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic md_is_div(input logic [2:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic md_is_signed(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/mdu_sched_md_compute.sv
// Combinational multiply/divide datapath producing the {hi,lo} pair and a
// divide-by-zero flag.
module md_compute
   import mdu_sched_pkg::*;
#(
   parameter int unsigned WIDTH = MD_WIDTH
) (
   input  logic [2:0]         op_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic [2*WIDTH-1:0] res_o,
   output logic               div_zero_o
);

   localparam int unsigned RES_W = 2 * WIDTH;

   logic               sgn;
   logic               is_div;
   logic [RES_W-1:0]   a_ext;
   logic [RES_W-1:0]   b_ext;
   logic [RES_W-1:0]   prod;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   b_safe;
   logic [WIDTH-1:0]   q_mag;
   logic [WIDTH-1:0]   r_mag;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   rem;
   logic               b_zero;

   // Multiply at double width; the low 2W bits are exact for both signednesses.
   always_comb begin
      sgn    = md_is_signed(op_i);
      is_div = md_is_div(op_i);
      a_ext  = sgn ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
      b_ext  = sgn ? {{WIDTH{b_i[WIDTH-1]}}, b_i} : {{WIDTH{1'b0}}, b_i};
      prod   = a_ext * b_ext;
   end

   // Divide on magnitudes, then restore signs: quotient truncates toward
   // zero and the remainder follows the dividend. -2^W-1 / -1 falls out as
   // quotient 0x80..0, remainder 0 through the unsigned magnitude path.
   always_comb begin
      a_neg  = sgn & a_i[WIDTH-1];
      b_neg  = sgn & b_i[WIDTH-1];
      a_mag  = a_neg ? WIDTH'(-a_i) : a_i;
      b_mag  = b_neg ? WIDTH'(-b_i) : b_i;
      b_zero = (b_i == '0);
      b_safe = b_zero ? WIDTH'(1) : b_mag;
      q_mag  = a_mag / b_safe;
      r_mag  = a_mag % b_safe;
      quot   = (a_neg ^ b_neg) ? WIDTH'(-q_mag) : q_mag;
      rem    = a_neg ? WIDTH'(-r_mag) : r_mag;
   end

   always_comb begin
      res_o      = prod;
      div_zero_o = 1'b0;
      if (is_div) begin
         res_o      = {rem, quot};
         div_zero_o = b_zero;
      end
   end

endmodule

// File: rtl/mdu_sched.sv
// Multiply/divide scheduler beside the EX-stage ALU: owns HI/LO, sequences
// multi-cycle ops with a busy counter and requests ID stalls for HI/LO users.
module mdu_sched #(
   parameter int unsigned WIDTH      = mdu_sched_pkg::MD_WIDTH,
   parameter int unsigned MUL_CYCLES = mdu_sched_pkg::MUL_CYCLES,
   parameter int unsigned DIV_CYCLES = mdu_sched_pkg::DIV_CYCLES
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             e_start,
   input  logic [2:0]       e_op,
   input  logic [WIDTH-1:0] e_rs_val,
   input  logic [WIDTH-1:0] e_rt_val,
   input  logic             d_md_use,
   output logic             busy,
   output logic             stall_d,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   import mdu_sched_pkg::*;

   localparam int unsigned MAX_CYC = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
   localparam int unsigned RES_W   = 2 * WIDTH;

   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic [RES_W-1:0] pend_q,    pend_d;
   logic             pend_ok_q, pend_ok_d;
   logic [WIDTH-1:0] hi_q,      hi_d;
   logic [WIDTH-1:0] lo_q,      lo_d;
   logic             busy_q,    busy_d;
   md_state_e        state;

   logic [RES_W-1:0] res;
   logic             div_zero;

   md_compute #(
      .WIDTH (WIDTH)
   ) u_md_compute (
      .op_i       (e_op),
      .a_i        (e_rs_val),
      .b_i        (e_rt_val),
      .res_o      (res),
      .div_zero_o (div_zero)
   );

   assign state = (cnt_q == '0) ? MD_IDLE : MD_RUN;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q     <= '0;
         pend_q    <= '0;
         pend_ok_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         pend_q    <= pend_d;
         pend_ok_q <= pend_ok_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
      end
   end

   // Starts are only honoured in IDLE; a start while running is dropped.
   always_comb begin
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      pend_ok_d = pend_ok_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state)
         MD_IDLE: begin
            if (e_start) begin
               case (e_op)
                  MD_MULT, MD_MULTU: begin
                     cnt_d     = CNT_W'(MUL_CYCLES);
                     pend_d    = res;
                     pend_ok_d = 1'b1;
                  end
                  MD_DIV, MD_DIVU: begin
                     cnt_d     = CNT_W'(DIV_CYCLES);
                     pend_d    = res;
                     pend_ok_d = ~div_zero;
                  end
                  MD_MTHI: hi_d = e_rs_val;
                  MD_MTLO: lo_d = e_rs_val;
                  default: ;
               endcase
            end
         end
         MD_RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if ((cnt_q == CNT_W'(1)) && pend_ok_q) begin
               hi_d = pend_q[RES_W-1:WIDTH];
               lo_d = pend_q[WIDTH-1:0];
            end
         end
         default: ;
      endcase
      busy_d = (cnt_d != '0);
   end

   assign busy    = busy_q;
   assign hi      = hi_q;
   assign lo      = lo_q;
   assign stall_d = d_md_use & (busy_q | e_start);

   a_no_start_while_busy: assert property (
      @(posedge clk) disable iff (!reset_n) !(e_start && busy_q)
   ) else $error("mdu_sched: e_start while busy");

endmodule

// File: tb/tb_mdu_sched.sv
// Randomized bench for mdu_sched against a cycle-number based reference
// model, plus directed cases with literal expected values.
module tb_mdu_sched;

   localparam int unsigned W  = 32;
   localparam int unsigned MC = 5;
   localparam int unsigned DC = 10;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          e_start;
   logic [2:0]    e_op;
   logic [W-1:0]  e_rs_val;
   logic [W-1:0]  e_rt_val;
   logic          d_md_use;
   logic          busy;
   logic          stall_d;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;

   mdu_sched #(
      .WIDTH      (W),
      .MUL_CYCLES (MC),
      .DIV_CYCLES (DC)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .e_start  (e_start),
      .e_op     (e_op),
      .e_rs_val (e_rs_val),
      .e_rt_val (e_rt_val),
      .d_md_use (d_md_use),
      .busy     (busy),
      .stall_d  (stall_d),
      .hi       (hi),
      .lo       (lo)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Reference arithmetic using the language's own signed/unsigned operators.
   function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint ua = longint'({32'd0, a});
      longint ub = longint'({32'd0, b});
      case (op)
         3'd0:    return 64'(sa * sb);
         3'd1:    return 64'(ua * ub);
         3'd2:    return {32'(sa % sb), 32'(sa / sb)};
         default: return {32'(ua % ub), 32'(ua / ub)};
      endcase
   endfunction

   // Model: an op started in cycle c keeps the unit busy for cycles c+1..c+N
   // and its result lands on the edge that ends cycle c+N.
   int           cyc = 0;
   int           m_done = 0;
   bit           m_active = 1'b0;
   bit           m_pok = 1'b0;
   logic [31:0]  m_hi = '0;
   logic [31:0]  m_lo = '0;
   logic [63:0]  m_pend = '0;
   bit           chk_en = 1'b0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_active = 1'b0;
         m_pok    = 1'b0;
         m_hi     = '0;
         m_lo     = '0;
      end else begin
         if (e_start && !m_active) begin
            if (e_op <= 3'd3) begin
               m_active = 1'b1;
               m_done   = cyc + ((e_op <= 3'd1) ? int'(MC) : int'(DC));
               m_pok    = !((e_op >= 3'd2) && (e_rt_val == '0));
               if (m_pok) m_pend = ref_result(e_op, e_rs_val, e_rt_val);
            end else if (e_op == 3'd4) begin
               m_hi = e_rs_val;
            end else if (e_op == 3'd5) begin
               m_lo = e_rs_val;
            end
         end else if (m_active && (cyc == m_done)) begin
            if (m_pok) {m_hi, m_lo} = m_pend;
            m_active = 1'b0;
         end
         cyc++;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy",    64'(busy),    64'(m_active));
         chk("stall_d", 64'(stall_d), 64'(d_md_use & (m_active | e_start)));
         chk("hi",      64'(hi),      64'(m_hi));
         chk("lo",      64'(lo),      64'(m_lo));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op, wait (bounded) for completion, check latency and HI/LO.
   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input int exp_n,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n = 0;
      e_start  = 1'b1;
      e_op     = op;
      e_rs_val = rs;
      e_rt_val = rt;
      tick();
      e_start = 1'b0;
      while (busy && n < 30) begin
         n++;
         tick();
      end
      chk({name, "_latency"}, 64'(n), 64'(exp_n));
      chk({name, "_hi"}, 64'(hi), 64'(exp_hi));
      chk({name, "_lo"}, 64'(lo), 64'(exp_lo));
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom % 6)
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom % 16);
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      reset_n  = 1'b0;
      e_start  = 1'b0;
      e_op     = 3'd0;
      e_rs_val = '0;
      e_rt_val = '0;
      d_md_use = 1'b1;
      #2;
      chk("reset_busy",  64'(busy),    64'd0);
      chk("reset_stall", 64'(stall_d), 64'd0);
      chk("reset_hi",    64'(hi),      64'd0);
      chk("reset_lo",    64'(lo),      64'd0);
      d_md_use = 1'b0;
      chk_en   = 1'b1;
      tick();
      tick();
      reset_n = 1'b1;
      tick();

      // mult -2 * 3 with mflo waiting in ID.
      e_start  = 1'b1;
      e_op     = 3'd0;
      e_rs_val = 32'hFFFF_FFFE;
      e_rt_val = 32'd3;
      d_md_use = 1'b1;
      #1;
      chk("b2b_stall_c0", 64'(stall_d), 64'd1);
      tick();
      e_start = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         chk("mult_busy_run", 64'(busy),    64'd1);
         chk("b2b_stall_run", 64'(stall_d), 64'd1);
         tick();
      end
      chk("mult_busy_done", 64'(busy),    64'd0);
      chk("b2b_stall_done", 64'(stall_d), 64'd0);
      chk("mult_hi",        64'(hi),      64'hFFFF_FFFF);
      chk("mult_lo",        64'(lo),      64'hFFFF_FFFA);
      d_md_use = 1'b0;
      tick();

      run_op("divu",     3'd3, 32'd100,        32'd7,        10, 32'd2,         32'd14);
      run_op("div_neg",  3'd2, 32'hFFFF_FFF9,  32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("mthi",     3'd4, 32'h1234_5678,  32'd0,        0,  32'h1234_5678, 32'hFFFF_FFFD);
      run_op("mthi_a",   3'd4, 32'hA,          32'd0,        0,  32'hA,         32'hFFFF_FFFD);
      run_op("mtlo_b",   3'd5, 32'hB,          32'd0,        0,  32'hA,         32'hB);
      run_op("div_zero", 3'd2, 32'd5,          32'd0,        10, 32'hA,         32'hB);
      run_op("div_ovf",  3'd2, 32'h8000_0000,  32'hFFFF_FFFF,10, 32'h0,         32'h8000_0000);
      run_op("multu_max",3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,5,  32'hFFFF_FFFE,  32'h1);
      run_op("mult_min", 3'd0, 32'h8000_0000,  32'h8000_0000,5,  32'h4000_0000,  32'h0);
      run_op("rsv6",     3'd6, 32'hDEAD_BEEF,  32'd1,        0,  32'h4000_0000,  32'h0);
      run_op("divu_zero",3'd3, 32'd9,          32'd0,        10, 32'h4000_0000,  32'h0);

      // Asynchronous reset in the middle of a div; no late write-back after.
      e_start  = 1'b1;
      e_op     = 3'd2;
      e_rs_val = 32'd9;
      e_rt_val = 32'd2;
      tick();
      e_start = 1'b0;
      tick();
      tick();
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_hi",   64'(hi),   64'd0);
      chk("arst_lo",   64'(lo),   64'd0);
      @(negedge clk);
      #2;
      reset_n = 1'b1;
      repeat (15) tick();
      chk("arst_no_wb_busy", 64'(busy), 64'd0);
      chk("arst_no_wb_hi",   64'(hi),   64'd0);
      chk("arst_no_wb_lo",   64'(lo),   64'd0);

      // Random traffic; starts only when the model says the unit is idle.
      for (int i = 0; i < 4000; i++) begin
         d_md_use = 1'($urandom);
         e_op     = 3'($urandom % 8);
         e_rs_val = pick_operand();
         e_rt_val = pick_operand();
         e_start  = !m_active && (($urandom % 3) == 0);
         if (($urandom % 300) == 0) begin
            e_start = 1'b0;
            #3;
            reset_n = 1'b0;
            #1;
            chk("rnd_arst_busy", 64'(busy), 64'd0);
            chk("rnd_arst_hi",   64'(hi),   64'd0);
            @(negedge clk);
            #2;
            reset_n = 1'b1;
         end
         tick();
      end
      e_start = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
